peripheral_display_scan: RTL

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It owns the shared segment bus and drives one digit at a time. A dead-time gap between digits suppresses ghosting. New display contents are double-buffered so they only change at frame boundaries. It sits between the CPU-side register interface (hex nibbles plus enable mask) and the board pins (anodes, segments).

---
 rtl/peripheral_display_pkg.sv | 17 +
 rtl/peripheral_scan_hexdec.sv | 11 +
 rtl/peripheral_display_scan.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/peripheral_display_pkg.sv
// rtl/peripheral_display_pkg.sv - shared constants, scan state type and hex font for the display scanner
package peripheral_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      GAP   = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Active-low gfedcba patterns for 0..F
   localparam logic [6:0] HEX_FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/peripheral_scan_hexdec.sv
// rtl/peripheral_scan_hexdec.sv - combinational hex nibble to active-low segment lookup
module peripheral_scan_hexdec
   import peripheral_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/peripheral_display_scan.sv
// rtl/peripheral_display_scan.sv - multiplexed 7-segment scan controller with frame-aligned double buffer
// Optional leading-zero blanking: LEADING_ZERO_BLANK_EN
module peripheral_display_scan
   import peripheral_display_pkg::*;
#(
   parameter int NDIGITS     = 4,
   parameter int SLOT_CYCLES = 50000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   wr_data,
   input  logic [NDIGITS-1:0]     wr_mask,
   output logic [NDIGITS-1:0]     an,
   output logic [6:0]             seg,
   output logic                   frame_tick,
   output logic                   pending
);

   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int IW = $clog2(NDIGITS);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

   scan_state_t          state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [IW-1:0]        idx, idx_nx;
   logic                 boundary;

   logic [4*NDIGITS-1:0] shadow_data, pend_data;
   logic [NDIGITS-1:0]   shadow_mask, pend_mask;
   logic [NDIGITS-1:0]   lz;

   logic [3:0]           nib;
   logic                 nib_en, nib_lz;
   logic [6:0]           dec_seg;
   logic [NDIGITS-1:0]   an_nx;
   logic [6:0]           seg_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      idx_nx   = idx;
      boundary = 1'b0;
      case (state)
         GAP: begin
            if (cnt == GAP_LAST) state_nx = DRIVE;
         end
         DRIVE: begin
            if (cnt == SLOT_LAST) begin
               state_nx = GAP;
               cnt_nx   = '0;
               idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
               boundary = (idx == IDX_LAST);
            end
         end
         default: begin
            state_nx = GAP;
            cnt_nx   = '0;
         end
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Enabled zero digits above the first nonzero enabled digit go dark; digit 0 always shows.
   always_comb begin
      logic seen;
      lz   = '0;
      seen = 1'b0;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
         if (shadow_mask[i]) begin
            if (shadow_data[i*4 +: 4] != 4'h0) seen = 1'b1;
            else if (!seen) lz[i] = 1'b1;
         end
      end
   end
`else
   assign lz = '0;
`endif

   always_comb begin
      nib    = 4'h0;
      nib_en = 1'b0;
      nib_lz = 1'b0;
      an_nx  = '1;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib    = shadow_data[i*4 +: 4];
            nib_en = shadow_mask[i];
            nib_lz = lz[i];
            if (state == DRIVE) an_nx[i] = 1'b0;
         end
      end
   end

   peripheral_scan_hexdec u_hexdec (
      .nibble (nib),
      .seg    (dec_seg)
   );

   // Masked digits keep their anode slot so brightness does not depend on content.
   assign seg_nx = (state == DRIVE && nib_en && !nib_lz) ? dec_seg : SEG_BLANK;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= GAP;
         cnt         <= '0;
         idx         <= '0;
         an          <= '1;
         seg         <= SEG_BLANK;
         frame_tick  <= 1'b0;
         pending     <= 1'b0;
         shadow_data <= '0;
         shadow_mask <= '0;
         pend_data   <= '0;
         pend_mask   <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         an         <= an_nx;
         seg        <= seg_nx;
         frame_tick <= boundary && (load || pending);
         if (boundary && load) begin
            shadow_data <= wr_data;
            shadow_mask <= wr_mask;
            pending     <= 1'b0;
         end else if (load) begin
            pend_data <= wr_data;
            pend_mask <= wr_mask;
            pending   <= 1'b1;
         end else if (boundary && pending) begin
            shadow_data <= pend_data;
            shadow_mask <= pend_mask;
            pending     <= 1'b0;
         end
      end
   end

endmodule
